sdram_image_write_ctrl: RTL and testbench

- Sequences transfer of decoded pixel bytes from the decoded-image FIFO into SDRAM.
- Started by the decoder's write-SDRAM trigger pulse. Packs byte pairs into 16-bit words and issues single-word Avalon-MM writes at consecutive addresses.
- Counts frames up to the latched image count, then reports completion.
- Sits between jtag_uart_decode (FIFO read side, image count, trigger) and the SDRAM controller's Avalon write port.

---
 rtl/sdram_image_write_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_sdram_image_write_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_image_write_ctrl.sv
// ============================================================================
// sdram_image_write_ctrl
// ----------------------------------------------------------------------------
// Moves decoded pixel bytes from the decoded-image FIFO into SDRAM.
// After a trigger pulse from the decoder, bytes are pulled from a show-ahead
// FIFO in pairs and packed little-endian into 16-bit words. The first byte
// goes to [7:0] and the second to [15:8]. Each word is then issued as a
// single Avalon-MM write at consecutive word addresses. Frames are counted
// up to the image count latched at the trigger, and completion is reported
// on oDONE.
//
// Optional build feature (macro SDRAM_WRITE_STALL_TIMEOUT_EN):
//   When defined, a starvation counter aborts the transfer. This happens
//   when the FIFO stays empty for TIMEOUT_CYCLES consecutive cycles while a
//   byte is awaited. The abort sets oERROR and returns to IDLE. When the
//   macro is undefined, the block waits for data indefinitely.
//
// Parameters:
//   FRAME_WORDS     16-bit words per frame
//   ADDR_W          SDRAM word-address width
//   BASE_ADDR       word address of frame 0
//   TIMEOUT_CYCLES  FIFO-starvation limit (optional feature only)
//
// Ports:
//   iCLK           system clock (single domain)
//   iRST           synchronous active-high reset
//   iTRIGGER       one-cycle start pulse from the decoder
//   iNUM_IMAGES    frames to write, sampled with the trigger
//   oFIFO_RDREQ    read acknowledge to the show-ahead FIFO
//   iFIFO_DATA     FIFO head byte, valid while iFIFO_EMPTY=0
//   iFIFO_EMPTY    FIFO empty flag
//   oSDRAM_ADDR    Avalon write word address
//   oSDRAM_WRITE   Avalon write request
//   oSDRAM_WRDATA  Avalon write data
//   iSDRAM_WAIT    Avalon waitrequest
//   oBUSY          transfer in progress
//   oDONE          all frames written; held until the next trigger
//   oFRAME_IDX     frames completed so far
//   oERROR         sticky error; cleared by reset or an accepted trigger
// ============================================================================
module sdram_image_write_ctrl #(
    parameter int                FRAME_WORDS    = 393216,
    parameter int                ADDR_W         = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int                TIMEOUT_CYCLES = 50000000
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iTRIGGER,
    input  logic [6:0]        iNUM_IMAGES,
    output logic              oFIFO_RDREQ,
    input  logic [7:0]        iFIFO_DATA,
    input  logic              iFIFO_EMPTY,
    output logic [ADDR_W-1:0] oSDRAM_ADDR,
    output logic              oSDRAM_WRITE,
    output logic [15:0]       oSDRAM_WRDATA,
    input  logic              iSDRAM_WAIT,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [6:0]        oFRAME_IDX,
    output logic              oERROR
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The word counter must be at least one bit wide, even for a
    // one-word frame.
    localparam int CNT_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GET_LO = 3'd1;
    localparam logic [2:0] ST_GET_HI = 3'd2;
    localparam logic [2:0] ST_WRITE  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [2:0]        stateReg,    stateNext;
    logic [6:0]        numReg,      numNext;
    logic [CNT_W-1:0]  wordCntReg,  wordCntNext;
    logic [6:0]        frameIdxReg, frameIdxNext;
    logic [ADDR_W-1:0] addrReg,     addrNext;
    logic              errorReg,    errorNext;
    logic [7:0]        laneReg [0:1];

    logic              busy;
    logic              fifoRead;
    logic              writeAccept;
    logic [6:0]        frameIdxInc;
    logic              stallTimeout;

    assign busy        = (stateReg == ST_GET_LO) || (stateReg == ST_GET_HI) ||
                         (stateReg == ST_WRITE);
    // A byte is consumed only when the FIFO actually presents one, so the
    // read acknowledge can never fire against an empty FIFO.
    assign fifoRead    = ((stateReg == ST_GET_LO) || (stateReg == ST_GET_HI)) &&
                         !iFIFO_EMPTY;
    assign writeAccept = (stateReg == ST_WRITE) && !iSDRAM_WAIT;
    assign frameIdxInc = frameIdxReg + 7'd1;

    // ------------------------------------------------------------------------
    // Optional FIFO-starvation watchdog
    // ------------------------------------------------------------------------
`ifdef SDRAM_WRITE_STALL_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT_CYCLES - 1);

    logic [STALL_W-1:0] stallCntReg;
    logic               starving;

    assign starving = ((stateReg == ST_GET_LO) || (stateReg == ST_GET_HI)) &&
                      iFIFO_EMPTY;

    // Any FIFO read or any cycle outside the byte-fetch states breaks the
    // starvation run, so the counter restarts from zero.
    always_ff @(posedge iCLK) begin
        if (iRST || !starving) begin
            stallCntReg <= '0;
        end else begin
            stallCntReg <= stallCntReg + STALL_W'(1);
        end
    end

    assign stallTimeout = starving && (stallCntReg == STALL_LIMIT);
`else
    // No watchdog is built. TIMEOUT_CYCLES stays in the parameter list so
    // both builds share one instantiation signature.
    logic unusedTimeoutParam;
    assign unusedTimeoutParam = (TIMEOUT_CYCLES > 0);
    assign stallTimeout       = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        stateNext    = stateReg;
        numNext      = numReg;
        wordCntNext  = wordCntReg;
        frameIdxNext = frameIdxReg;
        addrNext     = addrReg;
        errorNext    = errorReg;

        case (stateReg)
            ST_IDLE, ST_DONE: begin
                if (iTRIGGER) begin
                    numNext      = iNUM_IMAGES;
                    wordCntNext  = '0;
                    frameIdxNext = '0;
                    addrNext     = BASE_ADDR;
                    errorNext    = 1'b0;
                    // A zero-image request completes without touching SDRAM.
                    stateNext    = (iNUM_IMAGES == 7'd0) ? ST_DONE : ST_GET_LO;
                end
            end

            ST_GET_LO: begin
                if (!iFIFO_EMPTY) begin
                    stateNext = ST_GET_HI;
                end
            end

            ST_GET_HI: begin
                if (!iFIFO_EMPTY) begin
                    stateNext = ST_WRITE;
                end
            end

            ST_WRITE: begin
                // Address and data are registers, so they stay frozen
                // while waitrequest is asserted.
                if (writeAccept) begin
                    addrNext = addrReg + ADDR_W'(1);
                    if (wordCntReg == LAST_WORD) begin
                        wordCntNext  = '0;
                        frameIdxNext = frameIdxInc;
                        stateNext    = (frameIdxInc == numReg) ? ST_DONE : ST_GET_LO;
                    end else begin
                        wordCntNext = wordCntReg + CNT_W'(1);
                        stateNext   = ST_GET_LO;
                    end
                end
            end

            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        // A trigger during a transfer is not honoured, but it is flagged.
        if (busy && iTRIGGER) begin
            errorNext = 1'b1;
        end

        // The watchdog abort leaves oFRAME_IDX and the address untouched so
        // software can see how far the transfer got.
        if (stallTimeout) begin
            errorNext = 1'b1;
            stateNext = ST_IDLE;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateReg    <= ST_IDLE;
            numReg      <= '0;
            wordCntReg  <= '0;
            frameIdxReg <= '0;
            addrReg     <= BASE_ADDR;
            errorReg    <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            numReg      <= numNext;
            wordCntReg  <= wordCntNext;
            frameIdxReg <= frameIdxNext;
            addrReg     <= addrNext;
            errorReg    <= errorNext;
        end
    end

    // ------------------------------------------------------------------------
    // Byte-lane capture: lane 0 is filled in GET_LO, lane 1 in GET_HI.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gLane
            localparam logic [2:0] LANE_STATE = (gi == 0) ? ST_GET_LO : ST_GET_HI;

            always_ff @(posedge iCLK) begin
                if (iRST) begin
                    laneReg[gi] <= '0;
                end else if ((stateReg == LANE_STATE) && !iFIFO_EMPTY) begin
                    laneReg[gi] <= iFIFO_DATA;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign oFIFO_RDREQ   = fifoRead;
    assign oSDRAM_ADDR   = addrReg;
    assign oSDRAM_WRITE  = (stateReg == ST_WRITE);
    assign oSDRAM_WRDATA = {laneReg[1], laneReg[0]};
    assign oBUSY         = busy;
    assign oDONE         = (stateReg == ST_DONE);
    assign oFRAME_IDX    = frameIdxReg;
    assign oERROR        = errorReg;

endmodule

// File: tb/tb_sdram_image_write_ctrl.sv
// ============================================================================
// tb_sdram_image_write_ctrl
// ----------------------------------------------------------------------------
// Directed bench for sdram_image_write_ctrl with FRAME_WORDS=4.
// A small show-ahead FIFO model feeds bytes to the design. A monitor logs
// every accepted SDRAM write, printing one line per write. Expected values
// are hand-derived from the byte stream: word k carries {byte 2k+2, byte 2k+1}.
// ============================================================================
module tb_sdram_image_write_ctrl;

    localparam int FW = 4;
    localparam int AW = 24;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          iRST;
    logic          iTRIGGER;
    logic [6:0]    iNUM_IMAGES;
    logic          oFIFO_RDREQ;
    logic [7:0]    fifoData;
    logic          fifoEmpty;
    logic [AW-1:0] oSDRAM_ADDR;
    logic          oSDRAM_WRITE;
    logic [15:0]   oSDRAM_WRDATA;
    logic          iSDRAM_WAIT;
    logic          oBUSY;
    logic          oDONE;
    logic [6:0]    oFRAME_IDX;
    logic          oERROR;

    always #5 clk = ~clk;

    sdram_image_write_ctrl #(
        .FRAME_WORDS   (FW),
        .ADDR_W        (AW),
        .BASE_ADDR     ('0),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .iCLK         (clk),
        .iRST         (iRST),
        .iTRIGGER     (iTRIGGER),
        .iNUM_IMAGES  (iNUM_IMAGES),
        .oFIFO_RDREQ  (oFIFO_RDREQ),
        .iFIFO_DATA   (fifoData),
        .iFIFO_EMPTY  (fifoEmpty),
        .oSDRAM_ADDR  (oSDRAM_ADDR),
        .oSDRAM_WRITE (oSDRAM_WRITE),
        .oSDRAM_WRDATA(oSDRAM_WRDATA),
        .iSDRAM_WAIT  (iSDRAM_WAIT),
        .oBUSY        (oBUSY),
        .oDONE        (oDONE),
        .oFRAME_IDX   (oFRAME_IDX),
        .oERROR       (oERROR)
    );

    // ---------------- show-ahead FIFO model ----------------
    logic [7:0] fifoMem [0:255];
    int         wrPtr    = 0;
    int         rdPtr    = 0;
    logic       flushReq = 1'b0;

    assign fifoEmpty = (rdPtr == wrPtr);
    assign fifoData  = fifoMem[rdPtr[7:0]];

    // ---------------- monitor ----------------
    logic [AW-1:0] wrAddr [0:255];
    logic [15:0]   wrData [0:255];
    int            wrCount     = 0;
    int            rdCount     = 0;
    int            rdEmptyViol = 0;
    int            addr1Cyc    = 0;

    always @(posedge clk) begin
        if (flushReq) begin
            rdPtr <= wrPtr;
        end else if (oFIFO_RDREQ && !fifoEmpty) begin
            rdPtr <= rdPtr + 1;
        end
        if (!iRST) begin
            if (oFIFO_RDREQ) rdCount <= rdCount + 1;
            if (oFIFO_RDREQ && fifoEmpty) rdEmptyViol <= rdEmptyViol + 1;
            if (oSDRAM_WRITE && oSDRAM_ADDR == AW'(1)) addr1Cyc <= addr1Cyc + 1;
            if (oSDRAM_WRITE && !iSDRAM_WAIT) begin
                wrAddr[wrCount[7:0]] <= oSDRAM_ADDR;
                wrData[wrCount[7:0]] <= oSDRAM_WRDATA;
                wrCount <= wrCount + 1;
                $display("write #%0d addr=0x%06h data=0x%04h frame=%0d",
                         wrCount, oSDRAM_ADDR, oSDRAM_WRDATA, oFRAME_IDX);
            end
        end
    end

    // ---------------- checking ----------------
    int checkCnt = 0;
    int passCnt  = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushBytes(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            fifoMem[wrPtr[7:0]] = 8'(first + i);
            wrPtr = wrPtr + 1;
        end
    endtask

    task automatic trigger(input int n);
        iTRIGGER    = 1'b1;
        iNUM_IMAGES = 7'(n);
        tick();
        iTRIGGER    = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int limit);
        int c;
        c = 0;
        while (!oDONE && c < limit) begin
            tick();
            c++;
        end
        checkVal(tag, 32'(oDONE), 32'd1);
    endtask

    // Word k of a transfer whose stream starts at byte value b0 is
    // {b0+2k+1, b0+2k}. Addresses count up from addr0.
    task automatic checkWrites(input int base, input int n, input int addr0, input int b0);
        for (int k = 0; k < n; k++) begin
            checkVal("wr_addr", 32'(wrAddr[8'(base + k)]), 32'(addr0 + k));
            checkVal("wr_data", 32'(wrData[8'(base + k)]),
                     32'(((b0 + 2*k + 1) & 8'hFF) << 8 | ((b0 + 2*k) & 8'hFF)));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rdBase;
        int a1;
        int c;
        int last;
        int d;

        iRST        = 1'b1;
        iTRIGGER    = 1'b0;
        iNUM_IMAGES = 7'd0;
        iSDRAM_WAIT = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        iRST = 1'b0;

        // ---- reset state ----
        checkVal("rst_busy",  32'(oBUSY),        32'd0);
        checkVal("rst_done",  32'(oDONE),        32'd0);
        checkVal("rst_error", 32'(oERROR),       32'd0);
        checkVal("rst_frame", 32'(oFRAME_IDX),   32'd0);
        checkVal("rst_write", 32'(oSDRAM_WRITE), 32'd0);
        checkVal("rst_addr",  32'(oSDRAM_ADDR),  32'd0);
        checkVal("rst_rdreq", 32'(oFIFO_RDREQ),  32'd0);
        checkVal("rst_data",  32'(oSDRAM_WRDATA),32'd0);

        // ---- T1: one frame, no wait ----
        base = wrCount; rdBase = rdCount;
        pushBytes(1, 8);
        trigger(1);
        checkVal("t1_busy", 32'(oBUSY), 32'd1);
        waitDone("t1_done", 100);
        checkVal("t1_count", 32'(wrCount - base), 32'd4);
        checkWrites(base, 4, 0, 1);
        checkVal("t1_frame", 32'(oFRAME_IDX), 32'd1);
        checkVal("t1_reads", 32'(rdCount - rdBase), 32'd8);
        checkVal("t1_busy_end", 32'(oBUSY), 32'd0);

        // ---- T2: waitrequest held 5 cycles on the second write ----
        base = wrCount; rdBase = rdCount;
        pushBytes(1, 8);
        trigger(1);
        c = 0;
        while (!(oSDRAM_WRITE && oSDRAM_ADDR == AW'(1)) && c < 50) begin
            tick();
            c++;
        end
        checkVal("t2_reach", 32'(oSDRAM_WRITE && oSDRAM_ADDR == AW'(1)), 32'd1);
        a1 = addr1Cyc;
        iSDRAM_WAIT = 1'b1;
        repeat (5) begin
            tick();
            checkVal("t2_hold_write", 32'(oSDRAM_WRITE),  32'd1);
            checkVal("t2_hold_addr",  32'(oSDRAM_ADDR),   32'd1);
            checkVal("t2_hold_data",  32'(oSDRAM_WRDATA), 32'h0403);
        end
        iSDRAM_WAIT = 1'b0;
        waitDone("t2_done", 100);
        checkVal("t2_wcycles", 32'(addr1Cyc - a1), 32'd6);
        checkVal("t2_count", 32'(wrCount - base), 32'd4);
        checkWrites(base, 4, 0, 1);
        checkVal("t2_reads", 32'(rdCount - rdBase), 32'd8);

        // ---- T3: FIFO empty for 10 cycles between bytes 3 and 4 ----
        base = wrCount; rdBase = rdCount;
        pushBytes(1, 3);
        trigger(1);
        repeat (14) tick();
        checkVal("t3_rdreq",  32'(oFIFO_RDREQ), 32'd0);
        checkVal("t3_busy",   32'(oBUSY), 32'd1);
        checkVal("t3_partial",32'(wrCount - base), 32'd1);
        checkVal("t3_reads",  32'(rdCount - rdBase), 32'd3);
        pushBytes(4, 5);
        waitDone("t3_done", 100);
        checkVal("t3_viol",  32'(rdEmptyViol), 32'd0);
        checkVal("t3_count", 32'(wrCount - base), 32'd4);
        checkWrites(base, 4, 0, 1);

        // ---- T4: three frames ----
        base = wrCount;
        pushBytes(1, 24);
        trigger(3);
        last = wrCount;
        c = 0;
        while (!oDONE && c < 200) begin
            tick();
            c++;
            if (wrCount != last) begin
                last = wrCount;
                d = wrCount - base;
                checkVal("t4_frame", 32'(oFRAME_IDX), 32'(d / 4));
                checkVal("t4_done_step", 32'(oDONE), 32'(d == 12));
            end
        end
        checkVal("t4_done", 32'(oDONE), 32'd1);
        checkVal("t4_count", 32'(wrCount - base), 32'd12);
        checkWrites(base, 12, 0, 1);
        checkVal("t4_frame_end", 32'(oFRAME_IDX), 32'd3);

        // ---- T5: trigger while busy is ignored and flagged ----
        base = wrCount;
        pushBytes(1, 8);
        trigger(1);
        repeat (4) tick();
        trigger(5);
        checkVal("t5_error", 32'(oERROR), 32'd1);
        checkVal("t5_busy",  32'(oBUSY),  32'd1);
        waitDone("t5_done", 100);
        checkVal("t5_count", 32'(wrCount - base), 32'd4);
        checkVal("t5_frame", 32'(oFRAME_IDX), 32'd1);
        checkVal("t5_error_sticky", 32'(oERROR), 32'd1);

        // ---- T7: zero images -> DONE next cycle, error cleared ----
        base = wrCount;
        trigger(0);
        checkVal("t7_done",  32'(oDONE),  32'd1);
        checkVal("t7_busy",  32'(oBUSY),  32'd0);
        checkVal("t7_error", 32'(oERROR), 32'd0);
        checkVal("t7_frame", 32'(oFRAME_IDX), 32'd0);
        repeat (3) tick();
        checkVal("t7_nowrite", 32'(wrCount - base), 32'd0);

        // ---- T6: reset during WRITE, with a simultaneous trigger ----
        pushBytes(1, 8);
        trigger(1);
        c = 0;
        while (!(oSDRAM_WRITE && oSDRAM_ADDR == AW'(2)) && c < 50) begin
            tick();
            c++;
        end
        checkVal("t6_reach", 32'(oSDRAM_WRITE && oSDRAM_ADDR == AW'(2)), 32'd1);
        iRST        = 1'b1;
        iTRIGGER    = 1'b1;
        iNUM_IMAGES = 7'd1;
        tick();
        checkVal("t6_write", 32'(oSDRAM_WRITE), 32'd0);
        checkVal("t6_busy",  32'(oBUSY),        32'd0);
        checkVal("t6_addr",  32'(oSDRAM_ADDR),  32'd0);
        checkVal("t6_frame", 32'(oFRAME_IDX),   32'd0);
        checkVal("t6_done",  32'(oDONE),        32'd0);
        iRST     = 1'b0;
        iTRIGGER = 1'b0;
        flushReq = 1'b1;
        tick();
        flushReq = 1'b0;
        checkVal("t6_idle", 32'(oBUSY), 32'd0);

`ifdef SDRAM_WRITE_STALL_TIMEOUT_EN
        // ---- T8: starvation timeout in GET_LO ----
        trigger(1);
        repeat (15) tick();
        checkVal("t8_busy_before", 32'(oBUSY), 32'd1);
        tick();
        checkVal("t8_busy",  32'(oBUSY),      32'd0);
        checkVal("t8_error", 32'(oERROR),     32'd1);
        checkVal("t8_done",  32'(oDONE),      32'd0);
        checkVal("t8_frame", 32'(oFRAME_IDX), 32'd0);
        checkVal("t8_write", 32'(oSDRAM_WRITE), 32'd0);
`endif

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
